imem_loader: RTL and testbench

- Writer side of the 4096x32 instruction RAM port (address/clock/data/wren/q) that the MIPS core fetches from.
- Accepts a byte stream over a valid/ready handshake, checks a length header and a trailing XOR checksum, and assembles little-endian 32-bit words.
- Writes each word into consecutive RAM addresses, holding the core in reset while loading.
- Sits at the top level between a byte source (UART receiver or debug port) and the iram write port.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_word.sv | 53 +++++
 rtl/imem_loader.sv | 167 ++++++++++++++++
 tb/tb_imem_loader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-RAM loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    // Length header is a little-endian 16-bit word count.
    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_word.sv
// word_assembler: places incoming stream bytes into their little-endian lane
// of a 32-bit word and keeps a running XOR of every data byte pushed.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic [7:0]  acc,
    output logic        full
);

    logic [LANE_W-1:0] lane_reg;
    logic [7:0]        acc_reg;
    logic [7:0]        lane_data_reg [BYTES_PER_WORD];

    // Lane counter and checksum accumulator; both restart at the start of a session.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_reg <= '0;
            acc_reg  <= '0;
        end else if (clear) begin
            lane_reg <= '0;
            acc_reg  <= '0;
        end else if (push) begin
            lane_reg <= lane_reg + LANE_W'(1);
            acc_reg  <= acc_reg ^ din;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            // Each lane captures the byte pushed while the counter points at it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_data_reg[gi] <= '0;
                end else if (push && (lane_reg == LANE_W'(gi))) begin
                    lane_data_reg[gi] <= din;
                end
            end
            assign word[gi*8 +: 8] = lane_data_reg[gi];
        end
    endgenerate

    assign acc  = acc_reg;
    // Asserted while the next push completes the word.
    assign full = (lane_reg == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed, XOR-checksummed byte image and
// writes it as 32-bit words into the instruction RAM, holding the core in
// reset until the whole image has been accepted and verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096   // must equal 2**ADDR_W
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_data,
    output logic              ram_wren,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int LEN_W = LEN_BYTES * 8;

    state_t             state_reg, state_next;
    logic [7:0]         len_lo_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [ADDR_W-1:0]  ram_address_reg;
    logic [ADDR_W:0]    words_loaded_reg;
    logic               cpu_rst_reg;

    logic               xfer;
    logic               start_ok;
    logic [LEN_W-1:0]   len_in;
    logic [ADDR_W:0]    words_inc;
    logic               asm_push;
    logic               asm_full;
    logic [31:0]        asm_word;
    logic [7:0]         asm_acc;

    assign xfer      = byte_valid & byte_ready;
    // A restart is honoured only when no session is running.
    assign start_ok  = load_start && ((state_reg == IDLE) || (state_reg == ERR));
    assign len_in    = {byte_data, len_lo_reg};
    assign words_inc = words_loaded_reg + (ADDR_W+1)'(1);
    assign asm_push  = xfer && (state_reg == DATA);

    word_assembler u_asm (
        .clk   (clk),
        .rst   (rst),
        .clear (start_ok),
        .push  (asm_push),
        .din   (byte_data),
        .word  (asm_word),
        .acc   (asm_acc),
        .full  (asm_full)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE, ERR: begin
                if (load_start) state_next = LEN_LO;
            end
            LEN_LO: begin
                if (xfer) state_next = LEN_HI;
            end
            LEN_HI: begin
                if (xfer) begin
                    if ({1'b0, len_in} > (LEN_W+1)'(DEPTH)) state_next = ERR;
                    else if (len_in == '0)                  state_next = CHK;
                    else                                    state_next = DATA;
                end
            end
            DATA: begin
                if (xfer && asm_full) state_next = WRITE;
            end
            WRITE: begin
                if (LEN_W'(words_inc) == len_reg) state_next = CHK;
                else                              state_next = DATA;
            end
            CHK: begin
                if (xfer) state_next = (byte_data == asm_acc) ? DONE : ERR;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state only, so byte_ready never
    // depends on byte_valid.
    always_comb begin
        byte_ready = 1'b0;
        ram_wren   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        unique case (state_reg)
            LEN_LO, LEN_HI, DATA, CHK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            WRITE: begin
                ram_wren = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            ERR: begin
                error = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Session datapath: length header, write address, word count and core reset.
    // cpu_rst is released by the DONE cycle's edge, so the core starts one
    // cycle after the done pulse; ERR keeps it held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_lo_reg       <= '0;
            len_reg          <= '0;
            ram_address_reg  <= '0;
            words_loaded_reg <= '0;
            cpu_rst_reg      <= 1'b0;
        end else begin
            if (start_ok) begin
                ram_address_reg  <= '0;
                words_loaded_reg <= '0;
                cpu_rst_reg      <= 1'b1;
            end
            if (xfer && (state_reg == LEN_LO)) len_lo_reg <= byte_data;
            if (xfer && (state_reg == LEN_HI)) len_reg    <= len_in;
            if (state_reg == WRITE) begin
                ram_address_reg  <= ram_address_reg + ADDR_W'(1);
                words_loaded_reg <= words_inc;
            end
            if (state_reg == DONE) cpu_rst_reg <= 1'b0;
        end
    end

    assign ram_address  = ram_address_reg;
    assign ram_data     = asm_word;
    assign cpu_rst      = cpu_rst_reg;
    assign words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data  = 8'h00;
    logic              byte_ready;
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_data;
    logic              ram_wren;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .ram_address  (ram_address),
        .ram_data     (ram_data),
        .ram_wren     (ram_wren),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          checks     = 0;
    int          errors     = 0;
    int          wr_count   = 0;
    int          done_count = 0;
    int          wr_base;
    int          done_base;
    bit          gaps       = 1'b0;
    logic [43:0] exp_q [$];   // {address, data}
    logic [43:0] mon_e;
    logic [31:0] img [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write monitor: every ram_wren must match the oldest expected write.
    always @(negedge clk) begin
        if (done) done_count++;
        if (ram_wren) begin
            wr_count++;
            chk("wren_while_ready", {31'b0, byte_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_wren", {20'b0, ram_address}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", {20'b0, ram_address}, {20'b0, mon_e[43:32]});
                chk("wr_data", ram_data, mon_e[31:0]);
            end
        end
    end

    // Present one byte and hold it until the loader takes it; returns on the
    // negedge after the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int t;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (t = 0; t < 40 && !byte_ready; t++) @(negedge clk);
        chk("byte_accepted", {31'b0, byte_ready}, 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Header, words from img (expected writes queued as they are sent), then
    // the XOR of the data bytes with an optional corruption mask.
    task automatic send_image(input logic [7:0] mask);
        logic [7:0]  x;
        logic [15:0] n;
        x = 8'h00;
        n = 16'(img.size());
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back({12'(i), img[i]});
            for (int k = 0; k < 4; k++) begin
                send_byte(img[i][8*k +: 8]);
                x = x ^ img[i][8*k +: 8];
            end
        end
        send_byte(x ^ mask);
    endtask

    task automatic wait_done(input int max);
        int t;
        for (t = 0; t < max && !done; t++) @(negedge clk);
        chk("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic wait_error(input int max);
        int t;
        for (t = 0; t < max && !error; t++) @(negedge clk);
        chk("error_seen", {31'b0, error}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'b0, byte_ready}, 32'd0);
        chk({tag, "_addr"},  {20'b0, ram_address}, 32'd0);
        chk({tag, "_data"},  ram_data, 32'd0);
        chk({tag, "_wren"},  {31'b0, ram_wren}, 32'd0);
        chk({tag, "_cpurst"}, {31'b0, cpu_rst}, 32'd0);
        chk({tag, "_busy"},  {31'b0, busy}, 32'd0);
        chk({tag, "_done"},  {31'b0, done}, 32'd0);
        chk({tag, "_error"}, {31'b0, error}, 32'd0);
        chk({tag, "_words"}, {19'b0, words_loaded}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: all outputs low, a waiting byte is not taken.
        repeat (3) @(negedge clk);
        chk_reset_outputs("in_reset");
        rst = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        repeat (5) @(negedge clk);
        chk_reset_outputs("idle");
        chk("idle_writes", 32'(wr_count), 32'd0);
        byte_valid = 1'b0;
        $display("reset/idle: ready=%0b wren_count=%0d", byte_ready, wr_count);

        // Two-word load; data-byte XOR is 0x2A.
        img = '{32'h12345678, 32'hDEADBEEF};
        wr_base = wr_count; done_base = done_count;
        start_load();
        chk("start_busy", {31'b0, busy}, 32'd1);
        chk("start_cpurst", {31'b0, cpu_rst}, 32'd1);
        send_image(8'h00);
        wait_done(20);
        chk("done_cpurst_held", {31'b0, cpu_rst}, 32'd1);
        chk("done_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        chk("after_done_cpurst", {31'b0, cpu_rst}, 32'd0);
        chk("two_words_loaded", {19'b0, words_loaded}, 32'd2);
        chk("two_writes", 32'(wr_count - wr_base), 32'd2);
        chk("two_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("load n=2: writes=%0d words_loaded=%0d", wr_count - wr_base, words_loaded);

        // Same stream with random source gaps.
        gaps = 1'b1;
        wr_base = wr_count;
        start_load();
        send_image(8'h00);
        wait_done(40);
        @(negedge clk);
        chk("gap_words_loaded", {19'b0, words_loaded}, 32'd2);
        chk("gap_writes", 32'(wr_count - wr_base), 32'd2);
        chk("gap_cpurst", {31'b0, cpu_rst}, 32'd0);
        gaps = 1'b0;
        $display("load n=2 with gaps: writes=%0d", wr_count - wr_base);

        // Bad checksum: data XOR is 0x01, 0x02 is sent.
        img = '{32'h0000_0001};
        wr_base = wr_count; done_base = done_count;
        start_load();
        send_image(8'h03);
        wait_error(10);
        chk("badchk_cpurst", {31'b0, cpu_rst}, 32'd1);
        chk("badchk_busy", {31'b0, busy}, 32'd0);
        chk("badchk_ready", {31'b0, byte_ready}, 32'd0);
        chk("badchk_writes", 32'(wr_count - wr_base), 32'd1);
        chk("badchk_no_done", 32'(done_count - done_base), 32'd0);
        $display("load n=1 bad checksum: error=%0b cpu_rst=%0b", error, cpu_rst);

        // Restart from ERR clears the error; N=0 completes without writes.
        img.delete();
        wr_base = wr_count;
        start_load();
        chk("restart_error_clear", {31'b0, error}, 32'd0);
        chk("restart_busy", {31'b0, busy}, 32'd1);
        send_image(8'h00);
        wait_done(10);
        chk("n0_writes", 32'(wr_count - wr_base), 32'd0);
        chk("n0_words", {19'b0, words_loaded}, 32'd0);
        $display("load n=0: done=%0b writes=%0d", done, wr_count - wr_base);
        @(negedge clk);

        // Oversized header: 0x1001 words.
        wr_base = wr_count;
        start_load();
        send_byte(8'h01);
        send_byte(8'h10);
        chk("toolong_error", {31'b0, error}, 32'd1);
        chk("toolong_cpurst", {31'b0, cpu_rst}, 32'd1);
        chk("toolong_ready", {31'b0, byte_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("toolong_writes", 32'(wr_count - wr_base), 32'd0);
        $display("load n=0x1001: error=%0b writes=%0d", error, wr_count - wr_base);

        // Full-depth image.
        img.delete();
        for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
        wr_base = wr_count;
        start_load();
        send_image(8'h00);
        wait_done(20);
        @(negedge clk);
        chk("full_words", {19'b0, words_loaded}, 32'd4096);
        chk("full_addr_wrapped", {20'b0, ram_address}, 32'd0);
        chk("full_writes", 32'(wr_count - wr_base), 32'd4096);
        chk("full_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("load n=4096: writes=%0d words_loaded=%0d", wr_count - wr_base, words_loaded);

        // Reset in the middle of the second word.
        img = '{32'h1111_2222, 32'h3333_4444};
        start_load();
        send_byte(8'h02);
        send_byte(8'h00);
        exp_q.push_back({12'd0, img[0]});
        for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8]);
        for (int k = 0; k < 3; k++) send_byte(img[1][8*k +: 8]);
        chk("mid_addr_before", {20'b0, ram_address}, 32'd1);
        chk("mid_words_before", {19'b0, words_loaded}, 32'd1);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("mid-session reset: cpu_rst=%0b busy=%0b", cpu_rst, busy);

        // Fresh load after the reset starts again at address 0.
        img = '{32'hCAFE_F00D};
        wr_base = wr_count;
        start_load();
        send_image(8'h00);
        wait_done(20);
        @(negedge clk);
        chk("fresh_words", {19'b0, words_loaded}, 32'd1);
        chk("fresh_writes", 32'(wr_count - wr_base), 32'd1);
        chk("fresh_error", {31'b0, error}, 32'd0);
        $display("load n=1 after reset: writes=%0d", wr_count - wr_base);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
